// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM initiator: FSM states and the queued command word.
package sram_ctrl_pkg;

    localparam int CMD_DATA_W = 4;
    localparam int CMD_ADDR_W = 2;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CMD,
        S_RWAIT
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response port of the SRAM initiator.
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = CMD_DATA_W,
    parameter int ADDR_W = CMD_ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_ctrl_fifo.sv
// Two-entry in-order command queue between the request port and the FSM.
module sram_req_fifo
    import sram_ctrl_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  logic      pop_i,
    input  sram_cmd_t data_i,
    output sram_cmd_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    sram_cmd_t  mem_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = mem_q[rp_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/sram_ctrl.sv
// SRAM bus initiator: queues requests, sequences registered SRAM commands,
// returns read data on a one-cycle strobe and optionally zero-fills after reset.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W  = CMD_DATA_W,
    parameter int ADDR_W  = CMD_ADDR_W,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    sram_ctrl_if.slave        rq,
    output logic              init_done,
    output logic              sram_CS,
    output logic              sram_WE,
    output logic              sram_RD,
    output logic [ADDR_W-1:0] sram_Addr,
    output logic [DATA_W-1:0] sram_dataIn,
    input  logic [DATA_W-1:0] sram_Q
);

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic      push;
    logic      pop;
    logic      full;
    logic      empty;
    sram_cmd_t wr_cmd;
    sram_cmd_t head;

    assign rq.req_ready = done_q & ~full;
    assign push         = rq.req_valid & rq.req_ready;
    assign wr_cmd       = '{we: rq.req_we, addr: rq.req_addr, wdata: rq.req_wdata};

    sram_req_fifo u_fifo (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (wr_cmd),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
        pop     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                cs_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = cnt_q;
                din_d  = '0;
                cnt_d  = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_IDLE: begin
                done_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                // writes stream one per cycle; a read needs a turnaround cycle
                if (we_q && !empty) begin
                    pop = 1'b1;
                end else if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                rv_d    = 1'b1;
                rdata_d = sram_Q;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            cs_d   = 1'b1;
            we_d   = head.we;
            rd_d   = ~head.we;
            addr_d = head.addr;
            din_d  = head.wdata;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            if (INIT_EN) state_q <= S_INIT;
            else         state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
        end
    end

    assign init_done    = done_q;
    assign sram_CS      = cs_q;
    assign sram_WE      = we_q;
    assign sram_RD      = rd_q;
    assign sram_Addr    = addr_q;
    assign sram_dataIn  = din_q;
    assign rq.rsp_valid = rv_q;
    assign rq.rsp_rdata = rdata_q;

endmodule
